// File: rtl/input_logic.sv
// User-input front end: synchronises and debounces the execute/peek buttons,
// samples the slide switches and issues one EXEC strobe per accepted press.
module input_logic #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  SW,
    input  logic        KEY0b,
    input  logic        KEY1b,
    input  logic        DONE,
    output logic [9:0]  DIN,
    output logic        EXEC,
    output logic        PEEKb,
    output logic        BUSY
);

    localparam int unsigned SW_W  = 10;
    localparam int unsigned NKEY  = 2;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    logic [NKEY-1:0]  r_key_sync [SYNC_STAGES];
    logic [SW_W-1:0]  r_sw_sync  [SYNC_STAGES];
    logic [NKEY-1:0]  w_key;
    logic [SW_W-1:0]  w_sw;

    logic [CNT_W-1:0] r_cnt [NKEY];
    logic [NKEY-1:0]  r_stable;
    logic             w_press;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_exec;
    logic             w_exec_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic [SW_W-1:0]  r_din;
    logic [SW_W-1:0]  w_din_nxt;
    logic             r_peek;

    // Synchroniser chains; bit 0 = KEY0b, bit 1 = KEY1b
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_key_sync[i] <= '1;
                r_sw_sync[i]  <= '0;
            end
        end else begin
            r_key_sync[0] <= {KEY1b, KEY0b};
            r_sw_sync[0]  <= SW;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_key_sync[i] <= r_key_sync[i-1];
                r_sw_sync[i]  <= r_sw_sync[i-1];
            end
        end
    end

    assign w_key = r_key_sync[SYNC_STAGES-1];
    assign w_sw  = r_sw_sync[SYNC_STAGES-1];

    // Stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing edges
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stable <= '1;
            for (int unsigned k = 0; k < NKEY; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NKEY; k++) begin
                if (w_key[k] == r_stable[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable[k] <= w_key[k];
                    r_cnt[k]    <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    assign w_press = ~r_stable[0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_exec  <= 1'b0;
            r_busy  <= 1'b0;
            r_din   <= '0;
            r_peek  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_exec  <= w_exec_nxt;
            r_busy  <= w_busy_nxt;
            r_din   <= w_din_nxt;
            r_peek  <= ~r_stable[1];
        end
    end

    // A press is consumed once (issued or discarded) and owned until release
    always_comb begin
        w_state_nxt = r_state;
        w_exec_nxt  = 1'b0;
        w_busy_nxt  = r_busy;
        w_din_nxt   = r_din;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (w_press) begin
                    w_busy_nxt = 1'b1;
                    if (DONE) begin
                        w_state_nxt = ST_ISSUE;
                        w_exec_nxt  = 1'b1;
                        w_din_nxt   = w_sw;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_HOLD;
                w_busy_nxt  = 1'b1;
            end
            ST_HOLD: begin
                w_busy_nxt = 1'b1;
                if (!w_press) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign DIN   = r_din;
    assign EXEC  = r_exec;
    assign BUSY  = r_busy;
    assign PEEKb = r_peek;

endmodule

// File: tb/tb_input_logic.sv
// Directed bench for input_logic with a per-cycle behavioural reference model.
module tb_input_logic;

    localparam int unsigned D = 4;
    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] sw = '0;
    logic       key0b = 1'b1;
    logic       key1b = 1'b1;
    logic       done = 1'b1;
    logic [9:0] din;
    logic       exec_o;
    logic       peekb;
    logic       busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    input_logic #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .CLK(clk), .RST(rst), .SW(sw), .KEY0b(key0b), .KEY1b(key1b), .DONE(done),
        .DIN(din), .EXEC(exec_o), .PEEKb(peekb), .BUSY(busy)
    );

    always #5 clk = ~clk;

    // Reference model: delay lines, disagreement run lengths, press ownership
    bit       h0 [S];
    bit       h1 [S];
    bit [9:0] hsw [S];
    bit       stab [2];
    int       run [2];
    bit       owned;
    bit       m_exec;
    bit       m_peek;
    bit [9:0] m_din;

    always @(posedge clk) begin
        bit       s [2];
        bit [9:0] ssw;
        bit       p0;
        bit       p1;
        bit       ex_old;
        cyc++;
        if (rst) begin
            for (int i = 0; i < S; i++) begin h0[i] = 1; h1[i] = 1; hsw[i] = '0; end
            stab[0] = 1; stab[1] = 1; run[0] = 0; run[1] = 0;
            owned = 0; m_exec = 0; m_peek = 0; m_din = '0;
        end else begin
            s[0] = h0[S-1]; s[1] = h1[S-1]; ssw = hsw[S-1];
            p0 = !stab[0]; p1 = !stab[1]; ex_old = m_exec;
            m_exec = 0;
            if (!owned && p0) begin
                owned = 1;
                m_exec = done;
                if (done) m_din = ssw;
            end else if (owned && !ex_old && !p0) begin
                owned = 0;
            end
            m_peek = p1;
            for (int k = 0; k < 2; k++) begin
                if (s[k] == stab[k]) run[k] = 0;
                else begin
                    run[k]++;
                    if (run[k] == int'(D)) begin stab[k] = s[k]; run[k] = 0; end
                end
            end
            for (int i = S - 1; i > 0; i--) begin h0[i] = h0[i-1]; h1[i] = h1[i-1]; hsw[i] = hsw[i-1]; end
            h0[0] = key0b; h1[0] = key1b; hsw[0] = sw;
        end
    end

    // Per-cycle comparison plus event bookkeeping for the literal checks
    int n_exec = 0;
    int n_busy = 0;
    int exec_cyc = -1;
    int peek_rise = -1;
    int peek_fall = -1;
    bit prev_peek = 0;

    always @(negedge clk) begin
        if (cyc > 0) begin
            vectors++;
            if (exec_o !== m_exec || busy !== owned || peekb !== m_peek || din !== m_din) begin
                errors++;
                $display("FAIL model cyc=%0d got exec=%b busy=%b peek=%b din=%h want exec=%b busy=%b peek=%b din=%h",
                         cyc, exec_o, busy, peekb, din, m_exec, owned, m_peek, m_din);
            end
            if (exec_o === 1'b1) begin n_exec++; exec_cyc = cyc; end
            if (busy === 1'b1) n_busy++;
            if (peekb === 1'b1 && !prev_peek) peek_rise = cyc;
            if (peekb === 1'b0 && prev_peek) peek_fall = cyc;
            prev_peek = (peekb === 1'b1);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int bounce_runs [15] = '{2, 1, 3, 2, 1, 3, 3, 1, 2, 3, 1, 2, 3, 1, 2};
    int c0;
    int c1;
    int base_exec;

    initial begin
        tick(3);
        rst = 1'b0;
        check("reset_din", int'(din), 0);
        check("reset_exec", int'(exec_o), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_peek", int'(peekb), 0);

        // Bounce shorter than the debounce window
        for (int r = 0; r < 15; r++) begin
            key0b = (r % 2 == 0) ? 1'b0 : 1'b1;
            tick(bounce_runs[r]);
        end
        key0b = 1'b1;
        tick(12);
        check("bounce_exec", n_exec, 0);
        check("bounce_busy", n_busy, 0);
        check("bounce_din", int'(din), 0);

        // Clean press, DONE=1
        sw = 10'h2A5; done = 1'b1;
        c0 = cyc; key0b = 1'b0;
        tick(20);
        check("clean_busy_held", int'(busy), 1);
        key0b = 1'b1;
        tick(12);
        check("clean_exec_cyc", exec_cyc, c0 + 7);
        check("clean_exec_count", n_exec, 1);
        check("clean_din", int'(din), 'h2A5);
        check("clean_busy_rel", int'(busy), 0);

        // Press while controller busy is discarded
        done = 1'b0; sw = 10'h3FF;
        key0b = 1'b0;
        tick(10);
        check("nodone_busy", int'(busy), 1);
        done = 1'b1;
        tick(2);
        key0b = 1'b1;
        tick(12);
        check("nodone_exec", n_exec, 1);
        check("nodone_din", int'(din), 'h2A5);
        check("nodone_busy_rel", int'(busy), 0);
        sw = 10'h001;
        key0b = 1'b0;
        tick(10);
        key0b = 1'b1;
        tick(12);
        check("second_exec", n_exec, 2);
        check("second_din", int'(din), 'h001);

        // Peek button alone
        c0 = cyc; key1b = 1'b0;
        tick(10);
        c1 = cyc; key1b = 1'b1;
        tick(12);
        check("peek_rise", peek_rise, c0 + 7);
        check("peek_fall", peek_fall, c1 + 7);
        check("peek_exec", n_exec, 2);

        // Reset while holding
        sw = 10'h0F0; done = 1'b1;
        c0 = cyc; key0b = 1'b0;
        tick(10);
        check("rst_pre_exec_cyc", exec_cyc, c0 + 7);
        check("rst_pre_busy", int'(busy), 1);
        rst = 1'b1;
        tick(1);
        c1 = cyc;
        rst = 1'b0;
        check("rst_exec", int'(exec_o), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_din", int'(din), 0);
        tick(10);
        check("rst_re_exec_cyc", exec_cyc, c1 + 7);
        check("rst_re_din", int'(din), 'h0F0);
        key0b = 1'b1;
        tick(12);
        check("rst_exec_count", n_exec, 4);

        // Coincident execute and peek
        sw = 10'h155;
        base_exec = n_exec;
        c0 = cyc; key0b = 1'b0; key1b = 1'b0;
        tick(10);
        key0b = 1'b1; key1b = 1'b1;
        tick(12);
        check("both_exec_cyc", exec_cyc, c0 + 7);
        check("both_peek_rise", peek_rise, c0 + 7);
        check("both_exec_count", n_exec - base_exec, 1);
        check("both_din", int'(din), 'h155);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
